// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: frame sequencer for an oversampling UART receiver.
// Times each bit with an oversample edge counter and fires the start, data,
// parity and stop check strobes at the sample point of each bit.
//
// Ports
//   CLK          oversampling clock
//   RST          synchronous, active-high reset
//   RX_IN        serial line, idle high; only looked at in IDLE
//   PAR_EN       parity bit present (latched at frame start)
//   PRESCALE     oversampling ratio 8/16/32 (latched at frame start)
//   sampled_bit  majority-voted bit from the sampler (consumed downstream)
//   strt_glitch  start-check result, 1 = false start
//   par_err      registered parity-check result
//   stp_err      registered stop-check result
//   edge_cnt     oversample edge index within the current bit
//   bit_cnt      data bit index within the frame
//   dat_samp_en  data sampler enable (high whenever a frame is active)
//   strt_chk_en  start-check strobe
//   deser_en     deserializer shift strobe
//   par_chk_en   parity-check strobe
//   stp_chk_en   stop-check strobe
//   data_valid   one-cycle pulse for an accepted frame
//
// state  | meaning
// -------+-------------------------------------------------
// IDLE   | line idle, waiting for RX_IN low
// START  | timing the start bit, start check at mid-bit
// DATA   | timing 8 data bits, deserializer shift at mid-bit
// PARITY | timing the parity bit, parity check at mid-bit
// STOP   | timing the stop bit, frame verdict at its end

module uart_rx_ctrl (
  input  logic       CLK,
  input  logic       RST,
  input  logic       RX_IN,
  input  logic       PAR_EN,
  input  logic [5:0] PRESCALE,
  input  logic       sampled_bit,
  input  logic       strt_glitch,
  input  logic       par_err,
  input  logic       stp_err,
  output logic [5:0] edge_cnt,
  output logic [3:0] bit_cnt,
  output logic       dat_samp_en,
  output logic       strt_chk_en,
  output logic       deser_en,
  output logic       par_chk_en,
  output logic       stp_chk_en,
  output logic       data_valid
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t     state, state_nxt;
  logic [5:0] p_lat, p_nxt;
  logic       pe_lat, pe_nxt;
  logic [5:0] edge_nxt;
  logic [3:0] bit_nxt;
  logic [5:0] mid_nxt;
  logic       bit_end;
  logic       at_mid;
  logic       dv_nxt;

  // The sampled bit itself feeds the deserializer; this block only times it.
  logic unused_sampled_bit;
  assign unused_sampled_bit = sampled_bit;

  assign bit_end = (edge_cnt == p_lat - 6'd1);

  always_comb begin
    state_nxt = state;
    edge_nxt  = edge_cnt;
    bit_nxt   = bit_cnt;
    p_nxt     = p_lat;
    pe_nxt    = pe_lat;
    dv_nxt    = 1'b0;

    if (state != IDLE) begin
      edge_nxt = bit_end ? 6'd0 : edge_cnt + 6'd1;
    end

    case (state)
      IDLE: begin
        edge_nxt = 6'd0;
        bit_nxt  = 4'd0;
        if (!RX_IN) begin
          state_nxt = START;
          pe_nxt    = PAR_EN;
          case (PRESCALE)
            6'd16:   p_nxt = 6'd16;
            6'd32:   p_nxt = 6'd32;
            default: p_nxt = 6'd8;
          endcase
        end
      end
      START: begin
        if (bit_end) begin
          bit_nxt   = 4'd0;
          state_nxt = strt_glitch ? IDLE : DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_cnt == 4'd7) begin
            bit_nxt   = 4'd0;
            state_nxt = pe_lat ? PARITY : STOP;
          end else begin
            bit_nxt = bit_cnt + 4'd1;
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          bit_nxt   = 4'd0;
          state_nxt = STOP;
        end
      end
      STOP: begin
        if (bit_end) begin
          bit_nxt   = 4'd0;
          state_nxt = IDLE;
          dv_nxt    = !stp_err && (!pe_lat || !par_err);
        end
      end
      default: begin
        state_nxt = IDLE;
        edge_nxt  = 6'd0;
        bit_nxt   = 4'd0;
      end
    endcase
  end

  // Strobes are decoded from the next-cycle counters so they can be
  // registered and still line up with edge_cnt == P/2+1.
  assign mid_nxt = {1'b0, p_nxt[5:1]} + 6'd1;
  assign at_mid  = (edge_nxt == mid_nxt);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= IDLE;
      p_lat       <= 6'd0;
      pe_lat      <= 1'b0;
      edge_cnt    <= 6'd0;
      bit_cnt     <= 4'd0;
      dat_samp_en <= 1'b0;
      strt_chk_en <= 1'b0;
      deser_en    <= 1'b0;
      par_chk_en  <= 1'b0;
      stp_chk_en  <= 1'b0;
      data_valid  <= 1'b0;
    end else begin
      state       <= state_nxt;
      p_lat       <= p_nxt;
      pe_lat      <= pe_nxt;
      edge_cnt    <= edge_nxt;
      bit_cnt     <= bit_nxt;
      dat_samp_en <= (state_nxt != IDLE);
      strt_chk_en <= at_mid && (state_nxt == START);
      deser_en    <= at_mid && (state_nxt == DATA);
      par_chk_en  <= at_mid && (state_nxt == PARITY);
      stp_chk_en  <= at_mid && (state_nxt == STOP);
      data_valid  <= dv_nxt;
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: directed frames plus randomized line activity, checked
// every cycle against a frame-position model (cycles since start entry,
// split into bit index and edge index by division).

module tb_uart_rx_ctrl;

  logic       CLK = 1'b0;
  logic       RST, RX_IN, PAR_EN, sampled_bit, strt_glitch, par_err, stp_err;
  logic [5:0] PRESCALE;
  logic [5:0] edge_cnt;
  logic [3:0] bit_cnt;
  logic       dat_samp_en, strt_chk_en, deser_en, par_chk_en, stp_chk_en, data_valid;

  uart_rx_ctrl dut (
    .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .PAR_EN(PAR_EN), .PRESCALE(PRESCALE),
    .sampled_bit(sampled_bit), .strt_glitch(strt_glitch), .par_err(par_err),
    .stp_err(stp_err), .edge_cnt(edge_cnt), .bit_cnt(bit_cnt),
    .dat_samp_en(dat_samp_en), .strt_chk_en(strt_chk_en), .deser_en(deser_en),
    .par_chk_en(par_chk_en), .stp_chk_en(stp_chk_en), .data_valid(data_valid)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, $signed(act), $signed(exp), $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit         m_active = 1'b0;
  int         m_t, m_p;
  bit         m_pe;
  logic [5:0] e_edge;
  logic [3:0] e_bit;
  logic       e_dse, e_strt, e_deser, e_par, e_stp, e_dv;

  always @(posedge CLK) begin : model
    int b, e, nb, mid;
    e_dv = 1'b0;
    if (RST) begin
      m_active = 1'b0;
      m_t      = 0;
    end else if (!m_active) begin
      if (RX_IN === 1'b0) begin
        m_active = 1'b1;
        m_t      = 0;
        m_p      = (PRESCALE == 6'd16) ? 16 : (PRESCALE == 6'd32) ? 32 : 8;
        m_pe     = PAR_EN;
      end
    end else begin
      nb = m_pe ? 11 : 10;
      b  = m_t / m_p;
      e  = m_t % m_p;
      if (e == m_p - 1 && b == 0 && strt_glitch) begin
        m_active = 1'b0;
      end else if (e == m_p - 1 && b == nb - 1) begin
        m_active = 1'b0;
        e_dv     = !stp_err && (!m_pe || !par_err);
      end
      if (m_active) m_t++;
    end
    if (m_active) begin
      nb      = m_pe ? 11 : 10;
      b       = m_t / m_p;
      e       = m_t % m_p;
      mid     = m_p / 2 + 1;
      e_edge  = 6'(e);
      e_bit   = (b >= 1 && b <= 8) ? 4'(b - 1) : 4'd0;
      e_dse   = 1'b1;
      e_strt  = (e == mid) && (b == 0);
      e_deser = (e == mid) && (b >= 1) && (b <= 8);
      e_par   = (e == mid) && m_pe && (b == 9);
      e_stp   = (e == mid) && (b == nb - 1);
    end else begin
      e_edge  = 6'd0;
      e_bit   = 4'd0;
      e_dse   = 1'b0;
      e_strt  = 1'b0;
      e_deser = 1'b0;
      e_par   = 1'b0;
      e_stp   = 1'b0;
    end
  end

  // ---------------- compare + event log ----------------
  int   cyc = 0;
  logic prev_dse = 1'b0;
  int   start_q[$], idle_q[$], dv_q[$], deser_edges[$];
  int   dv_n, deser_n, strt_n, par_n, stp_n;
  int   strt_edge, par_edge;

  always @(posedge CLK) begin
    #1;
    cyc++;
    chk("edge_cnt",    32'(edge_cnt),    32'(e_edge));
    chk("bit_cnt",     32'(bit_cnt),     32'(e_bit));
    chk("dat_samp_en", 32'(dat_samp_en), 32'(e_dse));
    chk("strt_chk_en", 32'(strt_chk_en), 32'(e_strt));
    chk("deser_en",    32'(deser_en),    32'(e_deser));
    chk("par_chk_en",  32'(par_chk_en),  32'(e_par));
    chk("stp_chk_en",  32'(stp_chk_en),  32'(e_stp));
    chk("data_valid",  32'(data_valid),  32'(e_dv));
    if (dat_samp_en && !prev_dse) start_q.push_back(cyc);
    if (!dat_samp_en && prev_dse) idle_q.push_back(cyc);
    prev_dse = dat_samp_en;
    if (data_valid)  begin dv_n++;    dv_q.push_back(cyc); end
    if (deser_en)    begin deser_n++; deser_edges.push_back(int'(edge_cnt)); end
    if (strt_chk_en) begin strt_n++;  strt_edge = int'(edge_cnt); end
    if (par_chk_en)  begin par_n++;   par_edge  = int'(edge_cnt); end
    if (stp_chk_en)  stp_n++;
  end

  function automatic int qget(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  task automatic clear_stats();
    start_q.delete(); idle_q.delete(); dv_q.delete(); deser_edges.delete();
    dv_n = 0; deser_n = 0; strt_n = 0; par_n = 0; stp_n = 0;
    strt_edge = -1; par_edge = -1;
  endtask

  task automatic cyc_n(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic kick(input logic [5:0] p, input logic pe);
    PRESCALE = p;
    PAR_EN   = pe;
    RX_IN    = 1'b0;
    cyc_n(1);
    RX_IN    = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    RST = 1'b1; RX_IN = 1'b1; PAR_EN = 1'b0; PRESCALE = 6'd8;
    sampled_bit = 1'b0; strt_glitch = 1'b0; par_err = 1'b0; stp_err = 1'b0;
    clear_stats();
    cyc_n(3);
    chk("rst_dse",  32'(dat_samp_en), 0);
    chk("rst_edge", 32'(edge_cnt), 0);
    RST = 1'b0;
    cyc_n(5);
    chk("idle_after_rst_dse", 32'(dat_samp_en), 0);

    // P=8, no parity, good stop
    clear_stats();
    kick(6'd8, 1'b0);
    cyc_n(100);
    chk("a_deser_n", deser_n, 8);
    for (int i = 0; i < deser_edges.size(); i++) chk("a_deser_edge", deser_edges[i], 5);
    chk("a_stp_n", stp_n, 1);
    chk("a_par_n", par_n, 0);
    chk("a_dv_n", dv_n, 1);
    chk("a_dv_latency", qget(dv_q, 0) - qget(start_q, 0), 80);

    // P=16, parity on, parity error
    clear_stats();
    par_err = 1'b1;
    kick(6'd16, 1'b1);
    cyc_n(200);
    par_err = 1'b0;
    chk("b_par_n", par_n, 1);
    chk("b_par_edge", par_edge, 9);
    chk("b_dv_n", dv_n, 0);
    chk("b_frame_len", qget(idle_q, 0) - qget(start_q, 0), 176);

    // P=32 false start
    clear_stats();
    strt_glitch = 1'b1;
    PRESCALE = 6'd32; PAR_EN = 1'b0; RX_IN = 1'b0;
    cyc_n(10);
    RX_IN = 1'b1;
    cyc_n(60);
    strt_glitch = 1'b0;
    chk("c_strt_n", strt_n, 1);
    chk("c_strt_edge", strt_edge, 17);
    chk("c_deser_n", deser_n, 0);
    chk("c_frame_len", qget(idle_q, 0) - qget(start_q, 0), 32);

    // P=16 stop error
    clear_stats();
    stp_err = 1'b1;
    kick(6'd16, 1'b0);
    cyc_n(200);
    stp_err = 1'b0;
    chk("d_stp_n", stp_n, 1);
    chk("d_dv_n", dv_n, 0);

    // reset in DATA at bit_cnt 3, then a clean frame
    kick(6'd16, 1'b0);
    cyc_n(70);
    chk("e_pre_rst_bit", 32'(bit_cnt), 3);
    RST = 1'b1;
    cyc_n(1);
    chk("e_rst_dse", 32'(dat_samp_en), 0);
    chk("e_rst_bit", 32'(bit_cnt), 0);
    chk("e_rst_edge", 32'(edge_cnt), 0);
    RST = 1'b0;
    clear_stats();
    cyc_n(5);
    kick(6'd16, 1'b0);
    cyc_n(200);
    chk("e_dv_n", dv_n, 1);

    // back-to-back frames, PRESCALE changed mid first frame
    clear_stats();
    PRESCALE = 6'd8; PAR_EN = 1'b0; RX_IN = 1'b0;
    cyc_n(20);
    PRESCALE = 6'd16;
    cyc_n(66);
    RX_IN = 1'b1;
    cyc_n(200);
    chk("f_dv_n", dv_n, 2);
    chk("f_frame1_len", qget(dv_q, 0) - qget(start_q, 0), 80);
    chk("f_gap", qget(start_q, 1) - qget(start_q, 0), 81);
    chk("f_frame2_len", qget(dv_q, 1) - qget(start_q, 1), 160);

    // randomized line activity
    for (int i = 0; i < 20000; i++) begin
      int r;
      r = $urandom_range(0, 4);
      case (r)
        0: PRESCALE = 6'd8;
        1: PRESCALE = 6'd16;
        2: PRESCALE = 6'd32;
        3: PRESCALE = 6'($urandom_range(0, 63));
        default: PRESCALE = 6'd0;
      endcase
      RX_IN       = ($urandom_range(0, 15) != 0);
      PAR_EN      = 1'($urandom_range(0, 1));
      sampled_bit = 1'($urandom_range(0, 1));
      strt_glitch = ($urandom_range(0, 3) == 0);
      par_err     = 1'($urandom_range(0, 1));
      stp_err     = ($urandom_range(0, 2) == 0);
      RST         = ($urandom_range(0, 999) == 0);
      cyc_n(1);
    end
    RST = 1'b0; RX_IN = 1'b1;
    cyc_n(5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
